// File: rtl/frame_scanout_if.sv
// frame_scanout_if: frame buffer read port plus the outgoing pixel stream.
// Stream rule: a pixel transfers on a clock edge where pix_valid && pix_ready; the source holds data stable while pix_valid && !pix_ready.
interface frame_scanout_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 19
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] pix_data;
    logic [9:0]        pix_x;
    logic [9:0]        pix_y;
    logic              pix_last;

    modport master (
        output rd_en, rd_addr, pix_valid, pix_data, pix_x, pix_y, pix_last,
        input  rd_data, pix_ready
    );

    modport slave (
        input  rd_en, rd_addr, pix_valid, pix_data, pix_x, pix_y, pix_last,
        output rd_data, pix_ready
    );
endinterface

// File: rtl/frame_scanout.sv
// frame_scanout: raster-order frame buffer reader feeding a credit-controlled pixel FIFO.
// Optional macro FRAME_SCANOUT_DOUBLE_BUF_EN adds fb_sel_i to read the upper frame of a ping-pong pair.
module frame_scanout #(
    parameter int H_PIXELS   = 640,
    parameter int V_PIXELS   = 480,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 19,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            scan_start_i,
    output logic            scan_done_o,
`ifdef FRAME_SCANOUT_DOUBLE_BUF_EN
    input  logic            fb_sel_i,
`endif
    output logic [1:0]      state_o,
    frame_scanout_if.master bus
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int EW   = DATA_W + 21;
    localparam int TAIL = RD_LATENCY - 1;
    localparam logic [9:0] X_MAX = 10'(H_PIXELS - 1);
    localparam logic [9:0] Y_MAX = 10'(V_PIXELS - 1);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d, base;
    logic              pv_q [RD_LATENCY];
    logic [9:0]        px_q [RD_LATENCY];
    logic [9:0]        py_q [RD_LATENCY];
    logic              pl_q [RD_LATENCY];
    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d, inflight_q, inflight_d;
    logic              issue, last_px, credit_ok, push, pop;

    // A read may only issue if every outstanding pixel already has a FIFO slot reserved.
    assign credit_ok = (int'(count_q) + int'(inflight_q)) < FIFO_DEPTH;
    assign last_px   = (x_q == X_MAX) && (y_q == Y_MAX);
    assign push      = pv_q[TAIL];
    assign pop       = (count_q != '0) && bus.pix_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_WAIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        issue       = 1'b0;
        scan_done_o = 1'b0;
        case (state_q)
            S_WAIT: begin
                x_d    = '0;
                y_d    = '0;
                addr_d = '0;
                if (scan_start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (last_px) begin
                        x_d     = '0;
                        y_d     = '0;
                        addr_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (x_q == X_MAX) begin
                            x_d = '0;
                            y_d = y_q + 10'd1;
                        end else begin
                            x_d = x_q + 10'd1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (count_q == '0 && inflight_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                scan_done_o = 1'b1;
                if (!scan_start_i) state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

`ifdef FRAME_SCANOUT_DOUBLE_BUF_EN
    localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(H_PIXELS * V_PIXELS);
    logic fb_sel_q;
    always_ff @(posedge clk_i) begin
        if (rst_i)                                 fb_sel_q <= 1'b0;
        else if (state_q == S_WAIT && scan_start_i) fb_sel_q <= fb_sel_i;
    end
    assign base = fb_sel_q ? FRAME_SZ : '0;
`else
    assign base = '0;
`endif

    assign bus.rd_en   = issue;
    assign bus.rd_addr = addr_q + base;
    assign state_o     = state_q;

    // Coordinate tags travel beside the read so they meet rd_data at the pipeline tail.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pv_q[i] <= 1'b0;
                px_q[i] <= '0;
                py_q[i] <= '0;
                pl_q[i] <= 1'b0;
            end
        end else begin
            pv_q[0] <= issue;
            px_q[0] <= x_q;
            py_q[0] <= y_q;
            pl_q[0] <= last_px;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                px_q[i] <= px_q[i-1];
                py_q[i] <= py_q[i-1];
                pl_q[i] <= pl_q[i-1];
            end
        end
    end

    always_comb begin
        count_d    = count_q;
        inflight_d = inflight_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        case ({issue, push})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {bus.rd_data, px_q[TAIL], py_q[TAIL], pl_q[TAIL]};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    // Head comes straight from the storage registers, so it cannot move while stalled.
    assign bus.pix_valid = (count_q != '0);
    assign {bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_last} = mem_q[rd_ptr_q];
endmodule

// File: tb/tb_frame_scanout.sv
// tb_frame_scanout: randomized-ready frame reads checked against a raster-order pixel model.
// Build with FRAME_SCANOUT_DOUBLE_BUF_EN to also exercise the fb_sel ping-pong base.
module tb_frame_scanout;
    localparam int H     = 4;
    localparam int V     = 3;
    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int NPIX  = H * V;
    localparam int EW    = DW + 21;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_start = 1'b0;
    logic       scan_done;
    logic [1:0] state;
`ifdef FRAME_SCANOUT_DOUBLE_BUF_EN
    logic       fb_sel = 1'b0;
`endif

    frame_scanout_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    frame_scanout #(
        .H_PIXELS(H), .V_PIXELS(V), .DATA_W(DW), .ADDR_W(AW),
        .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .scan_start_i(scan_start),
        .scan_done_o(scan_done),
`ifdef FRAME_SCANOUT_DOUBLE_BUF_EN
        .fb_sel_i(fb_sel),
`endif
        .state_o(state),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Frame buffer model: data equals address, returned two cycles after the strobe.
    logic [AW-1:0] mem_d1 = '0;
    logic [AW-1:0] mem_d2 = '0;
    always @(posedge clk) begin
        mem_d1 <= bus.rd_en ? bus.rd_addr : '0;
        mem_d2 <= mem_d1;
    end
    assign bus.rd_data = DW'(mem_d2);

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc, first_valid, first_done, last_acc, max_out, issued, accepted;
    int stall_seen, stall_changes;
    bit prev_stall;
    logic [EW-1:0] prev_head;
    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int            rd_cyc_q[$];
    logic [EW-1:0] acc_q[$];
    logic [EW-1:0] exp_q[$];

    task automatic clear_stats();
        rd_q.delete(); rd_cyc_q.delete(); acc_q.delete();
        first_valid = -1; first_done = -1; last_acc = -1; start_cyc = -1;
        max_out = 0; issued = 0; accepted = 0;
        stall_seen = 0; stall_changes = 0; prev_stall = 1'b0;
    endtask

    // Reference frame: pixel p sits at (p % H, p / H) and reads address base + p.
    task automatic build_expected(input int base);
        exp_q.delete(); exp_addr_q.delete();
        for (int p = 0; p < NPIX; p++) begin
            logic lst;
            lst = (p == NPIX - 1);
            exp_addr_q.push_back(AW'(base + p));
            exp_q.push_back({DW'(base + p), 10'(p % H), 10'(p / H), lst});
        end
    endtask

    task automatic sample_now();
        logic [EW-1:0] head;
        cyc++;
        head = {bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_last};
        if (bus.rd_en) begin
            rd_q.push_back(bus.rd_addr);
            rd_cyc_q.push_back(cyc);
            issued++;
        end
        if (bus.pix_valid && first_valid < 0) first_valid = cyc;
        if (scan_done && first_done < 0) first_done = cyc;
        if (prev_stall) begin
            stall_seen++;
            if (!bus.pix_valid || head !== prev_head) stall_changes++;
        end
        prev_stall = bus.pix_valid && !bus.pix_ready;
        prev_head  = head;
        if (bus.pix_valid && bus.pix_ready) begin
            acc_q.push_back(head);
            last_acc = cyc;
            accepted++;
        end
        if (issued - accepted > max_out) max_out = issued - accepted;
    endtask

    task automatic cycle();
        #4;
        sample_now();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ready(input int mode, input int n);
        case (mode)
            0:       bus.pix_ready = 1'b1;
            1:       bus.pix_ready = (n % 2 == 0);
            default: bus.pix_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic start_pulse(input bit hold, input int mode);
        drive_ready(mode, 0);
        scan_start = 1'b1;
        cycle();
        start_cyc  = cyc;
        scan_start = hold;
    endtask

    task automatic wait_done(input int mode);
        for (int n = 1; n < 300 && first_done < 0; n++) begin
            drive_ready(mode, n);
            cycle();
        end
    endtask

    task automatic idle(input int n);
        bus.pix_ready = 1'b1;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic test_reset();
        logic [31:0] vals [8];
        string       names [8];
        rst = 1'b1;
        scan_start = 1'b0;
        bus.pix_ready = 1'b1;
        cycle();
        cycle();
        vals  = '{32'(scan_done), 32'(bus.rd_en), 32'(bus.rd_addr), 32'(bus.pix_valid),
                  32'(bus.pix_data), 32'(bus.pix_x), 32'(bus.pix_y), 32'(bus.pix_last)};
        names = '{"scan_done", "rd_en", "rd_addr", "pix_valid", "pix_data", "pix_x", "pix_y", "pix_last"};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (vals[i] !== 32'd0) begin
                errors++;
                $display("FAIL reset_%s act=%0h req=0", names[i], vals[i]);
            end
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_single_frame();
        logic [AW-1:0] a;
        logic [EW-1:0] p;
        int span;
        clear_stats();
        build_expected(0);
        start_pulse(1'b0, 0);
        wait_done(0);
        checks++;
        if (first_done < 0) begin errors++; $display("FAIL single_timeout act=no_done req=done"); end
        checks++;
        if (rd_q.size() != NPIX) begin errors++; $display("FAIL single_rd_count act=%0d req=%0d", rd_q.size(), NPIX); end
        for (int i = 0; i < NPIX; i++) begin
            a = (i < rd_q.size()) ? rd_q[i] : 'x;
            p = (i < acc_q.size()) ? acc_q[i] : 'x;
            checks++;
            if (a !== exp_addr_q[i]) begin errors++; $display("FAIL single_rd_addr[%0d] act=%0d req=%0d", i, a, exp_addr_q[i]); end
            checks++;
            if (p !== exp_q[i]) begin errors++; $display("FAIL single_pixel[%0d] act=%h req=%h", i, p, exp_q[i]); end
        end
        checks++;
        if (acc_q.size() != NPIX) begin errors++; $display("FAIL single_pix_count act=%0d req=%0d", acc_q.size(), NPIX); end
        span = (rd_cyc_q.size() == NPIX) ? rd_cyc_q[NPIX-1] - rd_cyc_q[0] : -1;
        checks++;
        if (span != NPIX - 1) begin errors++; $display("FAIL single_rd_back_to_back act=%0d req=%0d", span, NPIX - 1); end
        checks++;
        if (rd_cyc_q.size() == 0 || rd_cyc_q[0] != start_cyc + 1) begin
            errors++; $display("FAIL single_first_rd act=%0d req=%0d", (rd_cyc_q.size() > 0) ? rd_cyc_q[0] - start_cyc : -1, 1);
        end
        checks++;
        if (first_valid != start_cyc + 1 + LAT + 1) begin
            errors++; $display("FAIL single_first_valid act=%0d req=%0d", first_valid - start_cyc - 1, LAT + 1);
        end
        checks++;
        if (last_acc - first_valid != NPIX - 1) begin errors++; $display("FAIL single_throughput act=%0d req=%0d", last_acc - first_valid, NPIX - 1); end
        checks++;
        if (first_done <= last_acc) begin errors++; $display("FAIL single_done_order act=%0d req=>%0d", first_done, last_acc); end
        checks++;
        if (max_out > DEPTH) begin errors++; $display("FAIL single_overflow act=%0d req<=%0d", max_out, DEPTH); end
        idle(2);
    endtask

    task automatic test_stall();
        logic [EW-1:0] p;
        clear_stats();
        build_expected(0);
        start_pulse(1'b0, 3);
        bus.pix_ready = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        checks++;
        if (rd_q.size() != DEPTH) begin errors++; $display("FAIL stall_reads act=%0d req=%0d", rd_q.size(), DEPTH); end
        checks++;
        if (bus.pix_valid !== 1'b1 || bus.pix_data !== 8'd0) begin
            errors++; $display("FAIL stall_head act=%b/%0d req=1/0", bus.pix_valid, bus.pix_data);
        end
        wait_done(0);
        checks++;
        if (acc_q.size() != NPIX || first_done < 0) begin errors++; $display("FAIL stall_count act=%0d req=%0d", acc_q.size(), NPIX); end
        for (int i = 0; i < NPIX; i++) begin
            p = (i < acc_q.size()) ? acc_q[i] : 'x;
            checks++;
            if (p !== exp_q[i]) begin errors++; $display("FAIL stall_pixel[%0d] act=%h req=%h", i, p, exp_q[i]); end
        end
        checks++;
        if (max_out > DEPTH) begin errors++; $display("FAIL stall_overflow act=%0d req<=%0d", max_out, DEPTH); end
        idle(2);
    endtask

    task automatic test_toggle();
        logic [EW-1:0] p;
        clear_stats();
        build_expected(0);
        start_pulse(1'b0, 1);
        wait_done(1);
        checks++;
        if (acc_q.size() != NPIX || first_done < 0) begin errors++; $display("FAIL toggle_count act=%0d req=%0d", acc_q.size(), NPIX); end
        for (int i = 0; i < NPIX; i++) begin
            p = (i < acc_q.size()) ? acc_q[i] : 'x;
            checks++;
            if (p !== exp_q[i]) begin errors++; $display("FAIL toggle_pixel[%0d] act=%h req=%h", i, p, exp_q[i]); end
        end
        checks++;
        if (stall_seen == 0 || stall_changes != 0) begin
            errors++; $display("FAIL toggle_stable act=%0d_changes/%0d_stalls req=0_changes", stall_changes, stall_seen);
        end
        idle(2);
    endtask

    task automatic test_hold_start();
        logic [AW-1:0] a;
        logic [EW-1:0] p;
        int n_rd;
        clear_stats();
        build_expected(0);
        start_pulse(1'b1, 2);
        wait_done(2);
        n_rd = rd_q.size();
        bus.pix_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if (scan_done !== 1'b1) begin errors++; $display("FAIL hold_done[%0d] act=%b req=1", i, scan_done); end
        end
        checks++;
        if (rd_q.size() != n_rd || n_rd != NPIX) begin errors++; $display("FAIL hold_no_restart act=%0d req=%0d", rd_q.size(), NPIX); end
        scan_start = 1'b0;
        cycle();
        checks++;
        if (scan_done !== 1'b0) begin errors++; $display("FAIL hold_release act=%b req=0", scan_done); end
        idle(1);
        clear_stats();
        start_pulse(1'b0, 2);
        wait_done(2);
        checks++;
        if (rd_q.size() != NPIX || acc_q.size() != NPIX) begin
            errors++; $display("FAIL refire_count act=%0d/%0d req=%0d", rd_q.size(), acc_q.size(), NPIX);
        end
        for (int i = 0; i < NPIX; i++) begin
            a = (i < rd_q.size()) ? rd_q[i] : 'x;
            p = (i < acc_q.size()) ? acc_q[i] : 'x;
            checks++;
            if (a !== exp_addr_q[i] || p !== exp_q[i]) begin
                errors++; $display("FAIL refire[%0d] act=%0d/%h req=%0d/%h", i, a, p, exp_addr_q[i], exp_q[i]);
            end
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        logic [31:0]   vals [8];
        logic [EW-1:0] p;
        clear_stats();
        start_pulse(1'b0, 0);
        for (int n = 0; n < 50 && rd_q.size() < 5; n++) cycle();
        rst = 1'b1;
        cycle();
        vals = '{32'(scan_done), 32'(bus.rd_en), 32'(bus.rd_addr), 32'(bus.pix_valid),
                 32'(bus.pix_data), 32'(bus.pix_x), 32'(bus.pix_y), 32'(bus.pix_last)};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (vals[i] !== 32'd0) begin errors++; $display("FAIL midreset_out%0d act=%0h req=0", i, vals[i]); end
        end
        rst = 1'b0;
        idle(3);
        checks++;
        if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL midreset_flush act=%b req=0", bus.pix_valid); end
        clear_stats();
        build_expected(0);
        start_pulse(1'b0, 2);
        wait_done(2);
        checks++;
        if (acc_q.size() != NPIX || first_done < 0) begin errors++; $display("FAIL midreset_count act=%0d req=%0d", acc_q.size(), NPIX); end
        for (int i = 0; i < NPIX; i++) begin
            p = (i < acc_q.size()) ? acc_q[i] : 'x;
            checks++;
            if (p !== exp_q[i]) begin errors++; $display("FAIL midreset_pixel[%0d] act=%h req=%h", i, p, exp_q[i]); end
        end
        checks++;
        if (max_out > DEPTH) begin errors++; $display("FAIL midreset_overflow act=%0d req<=%0d", max_out, DEPTH); end
        idle(2);
    endtask

`ifdef FRAME_SCANOUT_DOUBLE_BUF_EN
    task automatic test_double_buf();
        logic [AW-1:0] a;
        logic [EW-1:0] p;
        clear_stats();
        build_expected(NPIX);
        fb_sel = 1'b1;
        start_pulse(1'b0, 2);
        for (int i = 0; i < 5; i++) begin
            drive_ready(2, i);
            cycle();
        end
        fb_sel = 1'b0;
        wait_done(2);
        checks++;
        if (rd_q.size() != NPIX || acc_q.size() != NPIX) begin
            errors++; $display("FAIL dbuf_count act=%0d/%0d req=%0d", rd_q.size(), acc_q.size(), NPIX);
        end
        for (int i = 0; i < NPIX; i++) begin
            a = (i < rd_q.size()) ? rd_q[i] : 'x;
            p = (i < acc_q.size()) ? acc_q[i] : 'x;
            checks++;
            if (a !== exp_addr_q[i] || p !== exp_q[i]) begin
                errors++; $display("FAIL dbuf[%0d] act=%0d/%h req=%0d/%h", i, a, p, exp_addr_q[i], exp_q[i]);
            end
        end
        idle(2);
    endtask
`endif

    initial begin
        bus.pix_ready = 1'b0;
        clear_stats();
        @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
        test_stall();
        test_toggle();
        test_hold_start();
        test_reset_mid();
`ifdef FRAME_SCANOUT_DOUBLE_BUF_EN
        test_double_buf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
